// File: rtl/qoa_spi_pkg.sv
// Shared types and constants for the QOA SPI master.
package qoa_spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StWait,
        StHold,
        StGap
    } spim_state_t;

    localparam int unsigned SPIM_CLK_DIV_DEFAULT = 4;
    localparam int unsigned SPI_BYTE_BITS        = 8;

endpackage

// File: rtl/qoa_spim_tick.sv
// Loadable half-period down-counter: tick pulses for one cycle every CLK_DIV cycles.
module qoa_spim_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tick
);
    localparam int unsigned    CntW   = $clog2(CLK_DIV);
    localparam logic [CntW-1:0] Reload = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - CntW'(1);
        if (load || tick) begin
            cnt_d = Reload;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/qoa_spi_master.sv
// SPI mode-0 initiator for the QOA decoder chip; SCLK is divided from sys_clk.
// Define QOA_SPIM_RX_EN to compile in the MISO receive path.
module qoa_spi_master
    import qoa_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = SPIM_CLK_DIV_DEFAULT
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       spi_sclk,
    output logic       spi_cs_n,
    output logic       spi_mosi,
    input  logic       spi_miso
);
    localparam logic [2:0] LastBit = 3'(SPI_BYTE_BITS - 1);

    spim_state_t state_q, state_d;
    logic [7:0]  tx_sr_q, tx_sr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        last_q, last_d;
    logic        sclk_q, sclk_d;
    logic        cs_n_q, cs_n_d;
    logic        tick, tick_load;
    logic        rise_stb, byte_done;

    // Every state entry restarts the half-period.
    assign tick_load = (state_d != state_q);

    qoa_spim_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (sys_clk),
        .rst_n(sys_rst_n),
        .load (tick_load),
        .tick (tick)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= StIdle;
            tx_sr_q   <= '0;
            bit_cnt_q <= '0;
            last_q    <= 1'b0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            tx_sr_q   <= tx_sr_d;
            bit_cnt_q <= bit_cnt_d;
            last_q    <= last_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_sr_d   = tx_sr_q;
        bit_cnt_d = bit_cnt_q;
        last_d    = last_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        tx_ready  = 1'b0;
        rise_stb  = 1'b0;
        byte_done = 1'b0;
        unique case (state_q)
            StIdle, StWait: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    tx_sr_d = tx_data;
                    last_d  = tx_last;
                    cs_n_d  = 1'b0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (tick) state_d = StShift;
            end
            StShift: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        rise_stb = 1'b1;
                    end else begin
                        // MOSI is the shift register MSB, so shifting presents the next bit.
                        tx_sr_d   = {tx_sr_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LastBit) begin
                            byte_done = 1'b1;
                            state_d   = last_q ? StHold : StWait;
                        end
                    end
                end
            end
            StHold: begin
                if (tick) begin
                    cs_n_d  = 1'b1;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (tick) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign spi_sclk = sclk_q;
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = tx_sr_q[7];
    assign busy     = (state_q != StIdle);

`ifdef QOA_SPIM_RX_EN
    logic [7:0] rx_sr_q, rx_data_q;
    logic       rx_valid_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= byte_done;
            if (rise_stb) rx_sr_q <= {rx_sr_q[6:0], spi_miso};
            if (byte_done) rx_data_q <= rx_sr_q;
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
`else
    logic unused_rx;
    assign unused_rx = spi_miso ^ rise_stb ^ byte_done;
    assign rx_valid  = 1'b0;
    assign rx_data   = '0;
`endif

endmodule
